// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared types and encodings for the run controller.
//   state_e        : controller state; its encoding is driven straight onto oSTATE
//   MODE_*         : iMODE encodings (halt / step / run-limited / run-full)
//   OST_*          : oSTATE encodings
//   mode_to_state  : maps an iMODE value to the state it selects
package run_ctrl_pkg;

  localparam logic [1:0] MODE_HALT     = 2'b00;
  localparam logic [1:0] MODE_STEP     = 2'b01;
  localparam logic [1:0] MODE_RUN_LIM  = 2'b10;
  localparam logic [1:0] MODE_RUN_FULL = 2'b11;

  localparam logic [1:0] OST_HALT  = 2'b00;
  localparam logic [1:0] OST_STEP  = 2'b01;
  localparam logic [1:0] OST_RUN   = 2'b10;
  localparam logic [1:0] OST_BREAK = 2'b11;

  typedef enum logic [1:0] {
    ST_HALT  = OST_HALT,
    ST_STEP  = OST_STEP,
    ST_RUN   = OST_RUN,
    ST_BREAK = OST_BREAK
  } state_e;

  // Both run modes share the RUN state; the rate only matters inside it.
  function automatic state_e mode_to_state(input logic [1:0] mode);
    state_e st;
    case (mode)
      MODE_HALT: st = ST_HALT;
      MODE_STEP: st = ST_STEP;
      default:   st = ST_RUN;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/run_ctrl_key_edge.sv
// key_edge -- conditions the raw step key into a one-cycle step event.
//   i_clk    in  1  clock
//   i_rst_n  in  1  synchronous active-low reset
//   i_key_n  in  1  raw asynchronous key, active-low
//   o_step   out 1  one-cycle pulse when the debounced level goes 1 -> 0
// The key is brought in through two flops, then a new level is accepted
// only after DEBOUNCE_CYCLES consecutive samples that differ from the
// currently accepted level. Any sample matching the accepted level
// restarts the count, so bounces shorter than the window are ignored.
module key_edge #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_step
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_step;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Released level everywhere, so leaving reset never looks like a press.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_step  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th differing sample: accept it.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_step  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl -- CPU run controller issuing single-cycle clock-enable pulses.
//   iCLK      in  1   clock
//   iRST_N    in  1   synchronous active-low reset
//   iMODE     in  2   00 halt, 01 step, 10 run-limited, 11 run-full
//   iSTEP_N   in  1   raw step key, active-low
//   iLIMIT    in  8   run-limited rate: one enable per (iLIMIT+1) ticks
//   iPC       in  32  CPU program counter
//   iBP_ADDR  in  32  breakpoint address
//   iBP_ARM   in  1   breakpoint enable
//   oCPU_EN   out 1   CPU clock-enable pulse
//   oCYCLES   out 32  number of enables issued (wraps)
//   oSTATE    out 2   00 HALT, 01 STEP, 10 RUN, 11 BREAK
// Build option: define RUN_CTRL_BREAKPOINT_EN to include the PC breakpoint
// comparator and the BREAK state. Without it iPC/iBP_ADDR/iBP_ARM are
// ignored and BREAK is unreachable.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 500000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [1:0]  iMODE,
  input  logic        iSTEP_N,
  input  logic [7:0]  iLIMIT,
  input  logic [31:0] iPC,
  input  logic [31:0] iBP_ADDR,
  input  logic        iBP_ARM,
  output logic        oCPU_EN,
  output logic [31:0] oCYCLES,
  output logic [1:0]  oSTATE
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_e        r_state;
  logic          r_cpu_en;
  logic [31:0]   r_cycles;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_rate;

  logic   w_step;
  logic   w_full;
  logic   w_lim;
  logic   w_tick;
  logic   w_rate_hit;
  logic   w_due;
  logic   w_bp_hit;
  state_e w_mode_state;

  key_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_edge (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_key_n (iSTEP_N),
    .o_step  (w_step)
  );

  assign w_full       = (iMODE == MODE_RUN_FULL);
  assign w_lim        = (iMODE == MODE_RUN_LIM);
  assign w_tick       = (r_tick == TICK_LAST);
  // Compared against the live iLIMIT, so lowering it below the current
  // count fires on the very next tick.
  assign w_rate_hit   = (r_rate >= iLIMIT);
  assign w_due        = w_full | (w_lim & w_tick & w_rate_hit);
  assign w_mode_state = mode_to_state(iMODE);

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign w_bp_hit = iBP_ARM & (iPC == iBP_ADDR);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{iPC, iBP_ADDR, iBP_ARM};
  assign w_bp_hit    = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= ST_HALT;
      r_cpu_en <= 1'b0;
      r_cycles <= '0;
      r_tick   <= '0;
      r_rate   <= '0;
    end else begin
      r_cpu_en <= 1'b0;

      case (r_state)
        ST_HALT: r_state <= w_mode_state;

        ST_STEP: begin
          r_state <= w_mode_state;
          // A step arriving while iMODE already moved away is dropped.
          if (w_step && (iMODE == MODE_STEP)) begin
            r_cpu_en <= 1'b1;
            r_cycles <= r_cycles + 32'd1;
          end
        end

        ST_RUN: begin
          if (w_due && w_bp_hit) begin
            r_state <= ST_BREAK;
          end else begin
            r_state <= w_mode_state;
            if (w_due) begin
              r_cpu_en <= 1'b1;
              r_cycles <= r_cycles + 32'd1;
            end
          end
        end

        ST_BREAK: begin
          if (iMODE == MODE_HALT) begin
            r_state <= ST_HALT;
          end else if (w_step) begin
            // Deliberately unchecked against the breakpoint so the CPU can
            // move off the breakpoint address.
            r_cpu_en <= 1'b1;
            r_cycles <= r_cycles + 32'd1;
            r_state  <= w_mode_state;
          end
        end

        default: r_state <= ST_HALT;
      endcase

      // Rate counters only advance while staying in RUN at the limited
      // rate; any other situation (including leaving RUN) clears them.
      if ((r_state == ST_RUN) && w_lim && !(w_due && w_bp_hit)) begin
        if (w_tick) begin
          r_tick <= '0;
          if (w_rate_hit) begin
            r_rate <= '0;
          end else begin
            r_rate <= r_rate + 8'd1;
          end
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end else begin
        r_tick <= '0;
        r_rate <= '0;
      end
    end
  end

  assign oCPU_EN = r_cpu_en;
  assign oCYCLES = r_cycles;
  assign oSTATE  = r_state;

endmodule
